// File: rtl/booth_mul_datapath.sv
// Sequential radix-2 Booth multiplier datapath: one Booth step per clock in DOING,
// driven by the external multiplier next-state logic through the 2-bit state code.
module booth_mul_datapath #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           state,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic [7:0]           count,
  output logic [2*WIDTH-1:0]   result
);

  localparam logic [1:0] ST_CLEAR  = 2'b00;
  localparam logic [1:0] ST_FINISH = 2'b01;
  localparam logic [1:0] ST_START  = 2'b10;
  localparam logic [1:0] ST_DOING  = 2'b11;

  // hi carries one extra bit so that +/- (-2^(WIDTH-1)) never overflows the accumulator
  logic [WIDTH:0]   hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             q1_r;
  logic [WIDTH-1:0] mcand_r;
  logic [7:0]       count_r;

  logic [WIDTH:0]   mcand_ext_s;
  logic [WIDTH:0]   hi_sum_s;

  // Booth add/subtract selection on {lo[0], q_1}
  always_comb begin
    mcand_ext_s = {mcand_r[WIDTH-1], mcand_r};
    hi_sum_s    = hi_r;
    case ({lo_r[0], q1_r})
      2'b01:   hi_sum_s = hi_r + mcand_ext_s;
      2'b10:   hi_sum_s = hi_r - mcand_ext_s;
      default: hi_sum_s = hi_r;
    endcase
  end

  // Datapath registers: reset/state-decoded load, step, or hold
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 8'd0;
      hi_r    <= '0;
      lo_r    <= '0;
      q1_r    <= 1'b0;
      mcand_r <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          count_r <= 8'd0;
          hi_r    <= '0;
          lo_r    <= '0;
          q1_r    <= 1'b0;
          mcand_r <= '0;
        end
        ST_START: begin
          count_r <= 8'(WIDTH);
          hi_r    <= '0;
          lo_r    <= multiplier;
          q1_r    <= 1'b0;
          mcand_r <= multiplicand;
        end
        ST_DOING: begin
          // count saturates at zero; the registers hold once the iterations are spent
          if (count_r != 8'd0) begin
            count_r <= count_r - 8'd1;
            hi_r    <= {hi_sum_s[WIDTH], hi_sum_s[WIDTH:1]};
            lo_r    <= {hi_sum_s[0], lo_r[WIDTH-1:1]};
            q1_r    <= lo_r[0];
          end else begin
            count_r <= count_r;
            hi_r    <= hi_r;
            lo_r    <= lo_r;
            q1_r    <= q1_r;
          end
        end
        ST_FINISH: begin
          count_r <= count_r;
          hi_r    <= hi_r;
          lo_r    <= lo_r;
          q1_r    <= q1_r;
          mcand_r <= mcand_r;
        end
      endcase
    end
  end

  assign count  = count_r;
  assign result = {hi_r[WIDTH-1:0], lo_r};

endmodule

// File: tb/tb_booth_mul_datapath.sv
// Directed self-checking bench for booth_mul_datapath with hand-computed products.
module tb_booth_mul_datapath;

  localparam logic [1:0] ST_CLEAR  = 2'b00;
  localparam logic [1:0] ST_FINISH = 2'b01;
  localparam logic [1:0] ST_START  = 2'b10;
  localparam logic [1:0] ST_DOING  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  state;
  logic [31:0] multiplier;
  logic [31:0] multiplicand;
  logic [7:0]  count;
  logic [63:0] result;

  int vectors = 0;
  int miscompares = 0;

  booth_mul_datapath #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .state(state),
    .multiplier(multiplier),
    .multiplicand(multiplicand),
    .count(count),
    .result(result)
  );

  always #5 clk = ~clk;

  // Apply one state for one rising edge; outputs are sampled 1 ns after the edge.
  task automatic tick(input logic [1:0] st);
    state = st;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // CLEAR, START, 32 DOING steps with count tracked each edge, then product check.
  task automatic run_mul(input string tag, input logic [31:0] mplr, input logic [31:0] mcnd,
                         input logic [63:0] exp);
    tick(ST_CLEAR);
    multiplier   = mplr;
    multiplicand = mcnd;
    tick(ST_START);
    chk({tag, "_count_start"}, 64'(count), 64'd32);
    for (int i = 1; i <= 32; i++) begin
      tick(ST_DOING);
      chk({tag, "_count"}, 64'(count), 64'(32 - i));
    end
    chk({tag, "_result"}, result, exp);
  endtask

  initial begin
    reset        = 1'b1;
    state        = ST_CLEAR;
    multiplier   = 32'd0;
    multiplicand = 32'd0;
    tick(ST_CLEAR);
    chk("reset_count_init", 64'(count), 64'd0);
    chk("reset_result_init", result, 64'd0);
    reset = 1'b0;

    // Reset mid-operation with count at 17
    multiplier   = 32'd1234;
    multiplicand = 32'd567;
    tick(ST_START);
    for (int i = 0; i < 15; i++) tick(ST_DOING);
    chk("pre_reset_count", 64'(count), 64'd17);
    reset = 1'b1;
    tick(ST_DOING);
    chk("mid_reset_count", 64'(count), 64'd0);
    chk("mid_reset_result", result, 64'd0);
    tick(ST_DOING);
    chk("mid_reset2_count", 64'(count), 64'd0);
    chk("mid_reset2_result", result, 64'd0);
    reset = 1'b0;

    // Positive operands, held through FINISH
    run_mul("pos", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    for (int i = 0; i < 5; i++) begin
      tick(ST_FINISH);
      chk("pos_finish_hold", result, 64'h0000_0000_0000_000F);
    end

    // Mixed sign, then count saturation in extra DOING cycles
    run_mul("mixed", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
    for (int i = 0; i < 5; i++) begin
      tick(ST_DOING);
      chk("sat_count", 64'(count), 64'd0);
      chk("sat_result", result, 64'hFFFF_FFFF_FFFF_FFD6);
    end
    tick(ST_FINISH);
    chk("mixed_finish", result, 64'hFFFF_FFFF_FFFF_FFD6);

    // Extreme operands
    run_mul("minmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_mul("maxmin", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    run_mul("negneg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);

    // START held for two cycles: last sample (9*-4) wins
    tick(ST_CLEAR);
    multiplier   = 32'd100;
    multiplicand = 32'd100;
    tick(ST_START);
    multiplier   = 32'd9;
    multiplicand = 32'hFFFF_FFFC;
    tick(ST_START);
    chk("restart_count", 64'(count), 64'd32);
    for (int i = 0; i < 32; i++) tick(ST_DOING);
    chk("restart_result", result, 64'hFFFF_FFFF_FFFF_FFDC);

    // Abort after 10 DOING cycles
    tick(ST_CLEAR);
    multiplier   = 32'd77;
    multiplicand = 32'd88;
    tick(ST_START);
    for (int i = 0; i < 10; i++) tick(ST_DOING);
    chk("abort_pre_count", 64'(count), 64'd22);
    tick(ST_CLEAR);
    chk("abort_count", 64'(count), 64'd0);
    chk("abort_result", result, 64'd0);

    // Fresh 12*12 with operands scrambled during DOING
    multiplier   = 32'd12;
    multiplicand = 32'd12;
    tick(ST_START);
    for (int i = 0; i < 32; i++) begin
      multiplier   = $urandom;
      multiplicand = $urandom;
      tick(ST_DOING);
    end
    chk("fresh_count", 64'(count), 64'd0);
    chk("fresh_result", result, 64'h0000_0000_0000_0090);
    tick(ST_FINISH);
    chk("fresh_finish", result, 64'h0000_0000_0000_0090);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
